// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding read at a time,
// and buffers returned instructions in a show-ahead FIFO for decode.
module if_prefetch_queue #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH      = 4,
    parameter int          DATA_W     = 64,
    parameter logic [7:0]  FETCH_SIZE = 8'b0000_1111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              rx_r_valid_i,
    input  logic              rx_r_ready_o,
    output logic [63:0]       rx_r_addr_i,
    output logic [7:0]        rx_r_size_i,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    input  logic [DATA_W-1:0] rx_data_read_o,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [63:0]       inst_pc
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [63:0]        fpc_reg, fpc_next;
    logic [63:0]        req_pc_reg, req_pc_next;
    logic [63:0]        addr_reg, addr_next;
    logic               kill_reg, kill_next;
    logic [PTR_W:0]     count_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic               push, pop;
    logic [31:0]        push_inst;

    logic [31:0]        inst_mem [DEPTH];
    logic [63:0]        pc_mem   [DEPTH];

    assign rx_r_valid_i  = (state_reg == ST_REQ);
    assign rx_data_ready = (state_reg == ST_WAIT);
    assign rx_r_addr_i   = addr_reg;
    assign rx_r_size_i   = FETCH_SIZE;

    assign push_inst = req_pc_reg[2] ? rx_data_read_o[63:32] : rx_data_read_o[31:0];

    // A redirect flushes the queue, so a pop in the same cycle must not move the read pointer.
    assign inst_valid = (count_reg != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? inst_mem[rd_ptr_reg] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 64'h0;

    always_comb begin
        state_next  = state_reg;
        fpc_next    = fpc_reg;
        req_pc_next = req_pc_reg;
        addr_next   = addr_reg;
        kill_next   = kill_reg;
        push        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Only one request is ever in flight, so count < DEPTH guarantees room for its data.
                if ((count_reg < DEPTH_C) && !redirect_valid) begin
                    state_next  = ST_REQ;
                    req_pc_next = fpc_reg;
                    addr_next   = {fpc_reg[63:3], 3'b000};
                end
            end
            ST_REQ: begin
                if (rx_r_ready_o) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rx_data_valid) begin
                    state_next = ST_IDLE;
                    kill_next  = 1'b0;
                    if (!kill_reg && !redirect_valid) begin
                        push     = 1'b1;
                        fpc_next = req_pc_reg + 64'd4;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The outstanding request still completes; kill marks its data as stale.
        if (redirect_valid) begin
            fpc_next = {redirect_pc[63:2], 2'b00};
            if ((state_reg == ST_REQ) || ((state_reg == ST_WAIT) && !rx_data_valid)) begin
                kill_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            fpc_reg    <= RESET_PC;
            req_pc_reg <= 64'h0;
            addr_reg   <= 64'h0;
            kill_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            fpc_reg    <= fpc_next;
            req_pc_reg <= req_pc_next;
            addr_reg   <= addr_next;
            kill_reg   <= kill_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (redirect_valid) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: the outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= push_inst;
            pc_mem[wr_ptr_reg]   <= req_pc_reg;
        end
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor instruction-fetch front end. Owns the fetch PC and issues single-outstanding reads on the core's read-request/read-data handshake bus.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (jal/jalr/branch/trap, resolved upstream into one redirect port) by flushing the FIFO and discarding in-flight responses.

Parameters:
RESET_PC, 64'h80000000, fetch PC after reset
DEPTH, 4, FIFO entries; power of two, >= 2
DATA_W, 64, read-data bus width; 64 only (inst select uses pc[2])
FETCH_SIZE, 8'b00001111, constant driven on rx_r_size_i

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  load new fetch PC this cycle
redirect_pc  input  64  redirect target; bits [1:0] forced to 0 internally
rx_r_valid_i  output  1  read request valid
rx_r_ready_o  input  1  read request accepted
rx_r_addr_i  output  64  read address (= fetch PC with bits [2:0] cleared)
rx_r_size_i  output  8  = FETCH_SIZE
rx_data_valid  input  1  read data valid
rx_data_ready  output  1  read data accept
rx_data_read_o  input  DATA_W  read data
inst_valid  output  1  FIFO head valid (count != 0)
inst_ready  input  1  decode accepts head
inst  output  32  head instruction
inst_pc  output  64  head PC

Behaviour:
- Reset (async, rst_n=0): fpc=RESET_PC, state=IDLE, count=0, kill=0, rx_r_valid_i=0, rx_r_addr_i=0, rx_data_ready=0, inst_valid=0, inst=0, inst_pc=0.
- States: IDLE, REQ, WAIT.
- IDLE: if count+0 < DEPTH and no redirect this cycle -> REQ. On that edge latch req_pc=fpc and rx_r_addr_i={fpc[63:3],3'b0}; rx_r_valid_i=1.
- REQ: rx_r_valid_i=1. rx_r_addr_i is held stable until rx_r_valid_i&&rx_r_ready_o, then -> WAIT. A request is never withdrawn.
- WAIT: rx_data_ready=1. On rx_data_valid&&rx_data_ready -> IDLE.
  - If kill=0: push {inst = req_pc[2] ? data[63:32] : data[31:0], pc = req_pc} and set fpc=req_pc+4.
  - If kill=1: drop the data and clear kill.
- rx_data_ready=0 outside WAIT.
- FIFO credit: a request is issued only when count < DEPTH, counting the in-flight slot as reserved, so a push never overflows.
- Push and pop in the same cycle: count unchanged.
- Output: show-ahead. Data accepted at edge N is visible on inst/inst_pc with inst_valid=1 after edge N. Pop on inst_valid&&inst_ready.
- inst/inst_pc are 0 when the FIFO is empty.
- Redirect (priority over everything):
  - fpc={redirect_pc[63:2],2'b0}; FIFO flushed (count=0, pointers=0); a pop in the same cycle is ignored.
  - In REQ or WAIT: set kill=1; the request completes normally and its data is dropped.
  - A response arriving the same cycle as a redirect is dropped, and kill is not left set.
  - In IDLE: no kill; next cycle issues at the new fpc.
  - Back-to-back redirects: the last one wins; kill stays 1 until the stale response drains.
- Sequential PC: fpc advances by 4 only on an accepted non-killed response.
- Throughput: at most one instruction per 3 cycles with zero-latency slaves (IDLE->REQ->WAIT).
- rst_n asserted mid-transaction: all state clears immediately. The slave is expected to be reset by the same rst_n.

Test Plan:
- Reset release, slave always ready, data=64'h00000013_00100093 at 0x80000000 -> rx_r_addr_i=0x80000000; inst=0x00100093, inst_pc=0x80000000. Next request addr=0x80000000 (pc 0x80000004) -> inst=0x00000013.
- inst_ready=0, DEPTH=4 -> exactly 4 entries buffered. rx_r_valid_i stays 0 while count=4; resumes one cycle after first pop.
- Redirect to 0x80001002 while in WAIT, stale data returns 2 cycles later -> stale data dropped, FIFO empty. Next request addr=0x80001000, inst_pc=0x80001000.
- Redirect in same cycle as rx_data_valid&&rx_data_ready -> response not pushed; kill=0 after. Next request addr=redirect_pc.
- rx_r_ready_o held 0 for 5 cycles with redirect in cycle 2 -> rx_r_addr_i unchanged throughout REQ. Response dropped; following request at new PC.
- rst_n pulsed low in WAIT -> all outputs at reset values same cycle. First request after release addr=RESET_PC.
